ahfp_mult: RTL and testbench
============================

Name: ahfp_mult

Overview:
- Pipelined IEEE-754 single-precision (binary32) floating-point multiplier: result = dataa × datab.
- Used as the multiply primitive of the arithmetic datapath.
- Fixed latency of 2 clock cycles; accepts a new operand pair every cycle.
- Round-to-nearest-even, denormals flushed to zero, no exception flag outputs.

Parameters:
- none (format fixed at binary32; latency fixed at 2)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all pipeline registers
- dataa  input  32  operand A, binary32 (sign[31], exp[30:23], frac[22:0])
- datab  input  32  operand B, binary32
- result  output  32  product, binary32, registered

Behaviour:
Reset and timing:
- While reset is high: result = 32'h00000000 and all stage registers are zero.
- Reset asserted mid-operation discards in-flight products.
- After reset deasserts, result stays 0 until the first sampled pair has had 2 rising edges.
- Latency: operands sampled at edge N appear on result after edge N+1 (2 register stages). No handshake, no enable, full throughput.

Stage 1 (registered):
- Unpack both operands and classify each as zero, normal, inf or NaN.
- An operand with exp==0 (zero or denormal) is treated as signed zero (flush-to-zero).
- Sign = sa XOR sb.
- Exponent sum = ea + eb − 127, held in a signed 10-bit value.
- 24×24 significand product with hidden bit 1, 48 bits wide.

Stage 2 (registered):
- Normalize: if prod[47] is set, take mantissa from prod[46:24] and add 1 to the exponent; otherwise take prod[45:23].
- Guard bit = next lower bit; sticky = OR of all remaining lower bits.
- Round to nearest, ties to even: increment when guard & (sticky | lsb).
- If the round carries out of the mantissa, the mantissa becomes 0 and the exponent increments.
- Final exponent ≥ 255: overflow, result = {sign, 8'hFF, 23'h0} (signed infinity).
- Final exponent ≤ 0 (evaluated after rounding): underflow, result = {sign, 31'h0} (signed zero, flush-to-zero output).

Special cases (override the arithmetic path):
- Either operand NaN -> 32'h7FC00000 (canonical quiet NaN, sign 0).
- Inf × zero (including a denormal operand) -> 32'h7FC00000.
- Inf × nonzero finite or inf -> signed infinity.
- Zero × finite -> signed zero, e.g. 0 × 0 = 32'h00000000 and −0 × 1.0 = 32'h80000000.

Other rules:
- No flags, no other rounding modes.
- Outputs are only ever: canonical NaN, ±inf, ±0, or normal numbers (never denormals).

Decomposition:
- Package ahfp_pkg holds:
  - constants EXP_W=8, MAN_W=23, BIAS=127
  - QNAN=32'h7FC00000, POS_INF=32'h7F800000
  - a packed typedef fp32_t {sign, exp, frac}
  - a class enum {ZERO, NORMAL, INF, NAN}
- One natural sub-module: ahfp_round_pack, the combinational normalize/round/overflow/underflow/pack logic feeding the stage-2 register.
- Unpack and classify stays in the top level.

Test Plan:
- Reset: hold reset high with dataa=datab=3F800000 -> result 00000000. Release reset -> result 3F800000 exactly 2 edges later.
- Basic products:
  - 00000000×00000000 -> 00000000
  - 3F800000×3F800000 -> 3F800000
  - 40000000×C0400000 -> C0C00000
  - 3FC00001×3FC00001 -> 40100002 (rounds up)
- Range limits:
  - 7F7FFFFF×40000000 -> 7F800000 (overflow)
  - 00800000×00800000 -> 00000000 (underflow)
  - 00000001×3F800000 -> 00000000 (denormal input FTZ)
  - 80000000×3F800000 -> 80000000
- Specials:
  - 7F800000×00000000 -> 7FC00000
  - 7FC00001×3F800000 -> 7FC00000
  - FF800000×40000000 -> FF800000
- Throughput: apply a new pair every cycle (1×1, 2×−3, 1.5×1.5) -> results 3F800000, C0C00000, 40100000 on consecutive cycles starting 2 edges after the first.
- Reset mid-stream: assert reset asynchronously between edges while products are in flight -> result goes to 00000000 immediately (before the next edge); in-flight products are never emitted.

Source files
------------

// File: rtl/ahfp_pkg.sv
// Shared binary32 constants, operand layout, classification and stage-1 record
// for the ahfp multiplier.
package ahfp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_t;

  // Biased exponent of zero covers denormals too, so they flush to signed zero.
  function automatic fp_class_t classify(input fp32_t x);
    fp_class_t c;
    if (x.exp == '0)
      c = ZERO;
    else if (x.exp == '1)
      c = (x.frac == '0) ? INF : NAN;
    else
      c = NORMAL;
    return c;
  endfunction

  typedef struct packed {
    logic               sign;
    fp_class_t          cls_a;
    fp_class_t          cls_b;
    logic signed [9:0]  exp;
    logic [47:0]        prod;
  } stage1_t;

endpackage

// File: rtl/ahfp_round_pack.sv
// Combinational normalize, round-to-nearest-even, overflow/underflow and pack
// of the raw 48-bit significand product. Zero latency, no flow control.
module ahfp_round_pack
  import ahfp_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp,
  input  logic [47:0]       prod,
  output logic [31:0]       res
);

  logic [MAN_W-1:0]  man;
  logic              guard;
  logic              sticky;
  logic              inc;
  logic [MAN_W:0]    man_rnd;
  logic signed [9:0] exp_norm;
  logic signed [9:0] exp_fin;

  always_comb begin
    if (prod[47]) begin
      man      = prod[46:24];
      guard    = prod[23];
      sticky   = |prod[22:0];
      exp_norm = exp + 10'sd1;
    end else begin
      man      = prod[45:23];
      guard    = prod[22];
      sticky   = |prod[21:0];
      exp_norm = exp;
    end

    inc     = guard & (sticky | man[0]);
    man_rnd = {1'b0, man} + {{MAN_W{1'b0}}, inc};
    // A carry out leaves the mantissa field all-zero, so only the exponent moves.
    exp_fin = exp_norm + (man_rnd[MAN_W] ? 10'sd1 : 10'sd0);

    res = {sign, exp_fin[EXP_W-1:0], man_rnd[MAN_W-1:0]};
    if (exp_fin >= 10'sd255)
      res = {sign, POS_INF[30:0]};
    else if (exp_fin <= 10'sd0)
      res = {sign, 31'd0};
  end

endmodule

// File: rtl/ahfp_mult.sv
// Pipelined binary32 multiplier, RNE, flush-to-zero, canonical quiet NaN.
// Latency 2 cycles, one operand pair per cycle, no backpressure.
module ahfp_mult
  import ahfp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);

  fp32_t       a;
  fp32_t       b;
  stage1_t     s1_d;
  stage1_t     s1_q;
  logic [31:0] rounded;
  logic [31:0] res_d;
  logic        any_inf;
  logic        any_zero;

  assign a = dataa;
  assign b = datab;

  always_comb begin
    s1_d       = '0;
    s1_d.sign  = a.sign ^ b.sign;
    s1_d.cls_a = classify(a);
    s1_d.cls_b = classify(b);
    s1_d.exp   = $signed({2'b00, a.exp}) + $signed({2'b00, b.exp}) - $signed(10'(BIAS));
    s1_d.prod  = {24'd0, 1'b1, a.frac} * {24'd0, 1'b1, b.frac};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      s1_q <= '0;
    else
      s1_q <= s1_d;
  end

  ahfp_round_pack u_round_pack (
    .sign (s1_q.sign),
    .exp  ($signed(s1_q.exp)),
    .prod (s1_q.prod),
    .res  (rounded)
  );

  assign any_inf  = (s1_q.cls_a == INF)  || (s1_q.cls_b == INF);
  assign any_zero = (s1_q.cls_a == ZERO) || (s1_q.cls_b == ZERO);

  // Class-driven results override the arithmetic path, NaN outranking everything.
  always_comb begin
    res_d = rounded;
    if ((s1_q.cls_a == NAN) || (s1_q.cls_b == NAN))
      res_d = QNAN;
    else if (any_inf && any_zero)
      res_d = QNAN;
    else if (any_inf)
      res_d = {s1_q.sign, POS_INF[30:0]};
    else if (any_zero)
      res_d = {s1_q.sign, 31'd0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      result <= '0;
    else
      result <= res_d;
  end

endmodule

// File: tb/tb_ahfp_mult.sv
// Self-checking bench for ahfp_mult: directed tables plus a randomized stream
// checked against an integer-arithmetic binary32 multiply model.
module tb_ahfp_mult;

  logic        clk;
  logic        reset;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;

  int checks;
  int errors;

  ahfp_mult dut (
    .clk    (clk),
    .reset  (reset),
    .dataa  (dataa),
    .datab  (datab),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact product, then round to 24 significant bits by comparing the
  // discarded remainder against one half unit, then apply FTZ range limits.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e, sh;
    longint unsigned p, q, rem, half;
    logic za, zb, ia, ib, na, nb;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 23'd0);
    ib = (eb == 255) && (b[22:0] == 23'd0);
    na = (ea == 255) && (a[22:0] != 23'd0);
    nb = (eb == 255) && (b[22:0] != 23'd0);
    if (na || nb) return 32'h7FC00000;
    if ((ia && zb) || (ib && za)) return 32'h7FC00000;
    if (ia || ib) return {s, 8'hFF, 23'd0};
    if (za || zb) return {s, 31'd0};
    p    = ((64'd1 << 23) + 64'(a[22:0])) * ((64'd1 << 23) + 64'(b[22:0]));
    sh   = (p >= (64'd1 << 47)) ? 24 : 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if ((rem > half) || ((rem == half) && q[0])) q = q + 64'd1;
    e = ea + eb - 127 + (sh - 23);
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    int k;
    k = $urandom_range(0, 15);
    f = 23'($urandom);
    case (k)
      0: e = 8'd0;
      1: begin e = 8'hFF; f = 23'd0; end
      2: begin e = 8'hFF; f = f | 23'd1; end
      3: e = 8'($urandom_range(1, 20));
      4: e = 8'($urandom_range(235, 254));
      5: begin e = 8'($urandom_range(100, 154)); f = 23'h7FFFFF ^ 23'($urandom_range(0, 15)); end
      default: e = 8'($urandom_range(90, 165));
    endcase
    return {1'($urandom), e, f};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    dataa = 32'h3F800000;
    datab = 32'h3F800000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (result !== 32'h00000000) begin
      errors++;
      $display("FAIL reset_hold: got %08h expected %08h", result, 32'h00000000);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (result !== 32'h00000000) begin
      errors++;
      $display("FAIL reset_first_edge: got %08h expected %08h", result, 32'h00000000);
    end
    @(posedge clk);
    #1;
    checks++;
    if (result !== 32'h3F800000) begin
      errors++;
      $display("FAIL reset_release: got %08h expected %08h", result, 32'h3F800000);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [15] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h3FC00001,
                             32'h7F7FFFFF, 32'h00800000, 32'h00000001, 32'h80000000,
                             32'h7F800000, 32'h7FC00001, 32'hFF800000, 32'h00000001,
                             32'h7F800000, 32'h3F800001, 32'h3FFFFFFF};
    logic [31:0] tb_ [15] = '{32'h00000000, 32'h3F800000, 32'hC0400000, 32'h3FC00001,
                              32'h40000000, 32'h00800000, 32'h3F800000, 32'h3F800000,
                              32'h00000000, 32'h3F800000, 32'h40000000, 32'h7F800000,
                              32'hBF800000, 32'h3F800001, 32'h3FFFFFFF};
    logic [31:0] te [15] = '{32'h00000000, 32'h3F800000, 32'hC0C00000, 32'h40100002,
                             32'h7F800000, 32'h00000000, 32'h00000000, 32'h80000000,
                             32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000,
                             32'hFF800000, 32'h3F800002, 32'h407FFFFE};
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      dataa = ta[i];
      datab = tb_[i];
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (result !== te[i]) begin
        errors++;
        $display("FAIL directed_%0d (%08h x %08h): got %08h expected %08h",
                 i, ta[i], tb_[i], result, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa [3] = '{32'h3F800000, 32'h40000000, 32'h3FC00000};
    logic [31:0] pb [3] = '{32'h3F800000, 32'hC0400000, 32'h3FC00000};
    logic [31:0] pe [3] = '{32'h3F800000, 32'hC0C00000, 32'h40100000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) begin
        dataa = pa[i];
        datab = pb[i];
      end
      @(posedge clk);
      #1;
      if (i >= 1) begin
        checks++;
        if (result !== pe[i-1]) begin
          errors++;
          $display("FAIL back_to_back_%0d: got %08h expected %08h", i - 1, result, pe[i-1]);
        end
      end
    end
  endtask

  task automatic test_random_stream();
    logic [31:0] expq [$];
    logic [31:0] expv;
    logic [31:0] qa [$];
    logic [31:0] qb [$];
    logic [31:0] va, vb;
    for (int i = 0; i <= 400; i++) begin
      @(negedge clk);
      if (i < 400) begin
        va = rand_op();
        vb = rand_op();
        dataa = va;
        datab = vb;
        qa.push_back(va);
        qb.push_back(vb);
        expq.push_back(ref_mul(va, vb));
      end
      @(posedge clk);
      #1;
      if (i >= 1) begin
        expv = expq.pop_front();
        va   = qa.pop_front();
        vb   = qb.pop_front();
        checks++;
        if (result !== expv) begin
          errors++;
          $display("FAIL random_%0d (%08h x %08h): got %08h expected %08h",
                   i - 1, va, vb, result, expv);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    dataa = 32'h3F800000;
    datab = 32'h40000000;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (result !== 32'h40000000) begin
      errors++;
      $display("FAIL midreset_before: got %08h expected %08h", result, 32'h40000000);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (result !== 32'h00000000) begin
      errors++;
      $display("FAIL midreset_async: got %08h expected %08h", result, 32'h00000000);
    end
    @(posedge clk);
    #1;
    checks++;
    if (result !== 32'h00000000) begin
      errors++;
      $display("FAIL midreset_held: got %08h expected %08h", result, 32'h00000000);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (result !== 32'h00000000) begin
      errors++;
      $display("FAIL midreset_flush: got %08h expected %08h", result, 32'h00000000);
    end
    @(posedge clk);
    #1;
    checks++;
    if (result !== 32'h40000000) begin
      errors++;
      $display("FAIL midreset_resume: got %08h expected %08h", result, 32'h40000000);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    dataa  = '0;
    datab  = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random_stream();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
